arb_rsp_router: RTL and testbench

ARB_RSP_ROUTER -- requirements
Module: arb_rsp_router

---
 rtl/arb_rsp_router.sv | 61 ++++++
 tb/tb_arb_rsp_router.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/arb_rsp_router.sv
// arb_rsp_router: grants arbitrated requests to a slave and routes in-order responses back to the requesting master.
module arb_rsp_router #(
    parameter int NumIn    = 4,
    parameter int MaxTrans = 4,
    parameter int RspWidth = 32,
    parameter int IdxWidth = $clog2(NumIn),
    parameter int CntWidth = $clog2(MaxTrans + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                arb_req_i,
    input  logic [IdxWidth-1:0] arb_idx_i,
    output logic                arb_gnt_o,
    output logic                slv_req_o,
    input  logic                slv_gnt_i,
    input  logic                slv_rsp_valid_i,
    input  logic [RspWidth-1:0] slv_rsp_data_i,
    output logic [NumIn-1:0]    mst_rsp_valid_o,
    output logic [RspWidth-1:0] mst_rsp_data_o,
    output logic [CntWidth-1:0] outstanding_o,
    output logic                unexp_rsp_o
);
    localparam int PtrWidth = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
    logic [IdxWidth-1:0] fifo_q [MaxTrans];
    logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic unexp_q, unexp_d, full, empty, push, pop;
    // full/empty come from the registered count only, so a same-cycle pop never frees a slot for a push
    always_comb begin
        full            = cnt_q == CntWidth'(MaxTrans);
        empty           = cnt_q == '0;
        push            = arb_req_i & slv_gnt_i & ~full;
        pop             = slv_rsp_valid_i & ~empty;
        slv_req_o       = arb_req_i & ~full;
        arb_gnt_o       = slv_gnt_i & ~full;
        mst_rsp_valid_o = pop ? NumIn'(1) << fifo_q[rd_ptr_q] : '0;
        mst_rsp_data_o  = slv_rsp_data_i;
        wr_ptr_d        = push ? (wr_ptr_q == PtrWidth'(MaxTrans - 1) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
        rd_ptr_d        = pop ? (rd_ptr_q == PtrWidth'(MaxTrans - 1) ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
        cnt_d           = cnt_q + CntWidth'(push) - CntWidth'(pop);
        unexp_d         = slv_rsp_valid_i & empty;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            unexp_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            unexp_q  <= unexp_d;
        end
    end
    always_ff @(posedge clk_i) begin
        if (push && !rst_i) fifo_q[wr_ptr_q] <= arb_idx_i;
    end
    assign outstanding_o = cnt_q;
    assign unexp_rsp_o   = unexp_q;
endmodule

// File: tb/tb_arb_rsp_router.sv
// tb_arb_rsp_router: checks two router instances (MaxTrans 4 and 3) against a queue-based reference model.
module tb_arb_rsp_router;
    logic        clk = 1'b0, rst = 1'b1;
    logic        arb_req = 1'b0, slv_gnt = 1'b0, rsp_v = 1'b0;
    logic [1:0]  arb_idx = '0;
    logic [31:0] rsp_d = '0;
    logic        a_gnt, a_sreq, a_unexp, b_gnt, b_sreq, b_unexp;
    logic [3:0]  a_mv, b_mv;
    logic [31:0] a_md, b_md;
    logic [2:0]  a_out;
    logic [1:0]  b_out;
    logic [9:0]  obs [2];
    int          q [2][$];
    int          mt [2] = '{4, 3};
    bit          um [2] = '{1'b0, 1'b0};
    int          checks = 0, passes = 0;

    always #5 clk = ~clk;

    arb_rsp_router #(.NumIn(4), .MaxTrans(4), .RspWidth(32)) dut_a (
        .clk_i(clk), .rst_i(rst), .arb_req_i(arb_req), .arb_idx_i(arb_idx), .arb_gnt_o(a_gnt),
        .slv_req_o(a_sreq), .slv_gnt_i(slv_gnt), .slv_rsp_valid_i(rsp_v), .slv_rsp_data_i(rsp_d),
        .mst_rsp_valid_o(a_mv), .mst_rsp_data_o(a_md), .outstanding_o(a_out), .unexp_rsp_o(a_unexp));
    arb_rsp_router #(.NumIn(4), .MaxTrans(3), .RspWidth(32)) dut_b (
        .clk_i(clk), .rst_i(rst), .arb_req_i(arb_req), .arb_idx_i(arb_idx), .arb_gnt_o(b_gnt),
        .slv_req_o(b_sreq), .slv_gnt_i(slv_gnt), .slv_rsp_valid_i(rsp_v), .slv_rsp_data_i(rsp_d),
        .mst_rsp_valid_o(b_mv), .mst_rsp_data_o(b_md), .outstanding_o(b_out), .unexp_rsp_o(b_unexp));

    assign obs[0] = {a_sreq, a_gnt, a_mv, a_out, a_unexp};
    assign obs[1] = {b_sreq, b_gnt, b_mv, 1'b0, b_out, b_unexp};

    // Expected {slv_req, arb_gnt, mst_valid, outstanding, unexp} for instance k from the current inputs.
    function automatic logic [9:0] exp_vec(int k);
        bit full, empty;
        logic [3:0] mv;
        full  = q[k].size() == mt[k];
        empty = q[k].size() == 0;
        mv    = (rsp_v && !empty) ? 4'(1 << q[k][0]) : 4'b0;
        return {1'(arb_req && !full), 1'(slv_gnt && !full), mv, 3'(q[k].size()), 1'(um[k])};
    endfunction

    task automatic model_commit();
        for (int k = 0; k < 2; k++) begin
            bit full, empty;
            full  = q[k].size() == mt[k];
            empty = q[k].size() == 0;
            if (rst) begin
                q[k].delete();
                um[k] = 1'b0;
            end else begin
                um[k] = rsp_v && empty;
                if (rsp_v && !empty) void'(q[k].pop_front());
                if (arb_req && slv_gnt && !full) q[k].push_back(int'(arb_idx));
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    task automatic drive(input logic req, input logic [1:0] idx, input logic gnt, input logic rv, input logic [31:0] d);
        arb_req = req; arb_idx = idx; slv_gnt = gnt; rsp_v = rv; rsp_d = d;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        step(); step();
        drive(1, 3, 1, 1, 32'h55);
        checks++; if (a_sreq !== 1'b1 || a_mv !== 4'b0 || a_out !== 3'd0 || a_unexp !== 1'b0)
            $display("FAIL reset_state got sreq=%b mv=%b out=%0d unexp=%b exp 1 0000 0 0", a_sreq, a_mv, a_out, a_unexp);
        else passes++;
        for (int k = 0; k < 2; k++) begin
            checks++; if (obs[k] !== exp_vec(k)) $display("FAIL reset_vec%0d got %b exp %b", k, obs[k], exp_vec(k)); else passes++;
        end
        step();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0);
        step();
    endtask

    task automatic test_single();
        drive(1, 2, 1, 0, 0);
        checks++; if (a_gnt !== 1'b1 || a_sreq !== 1'b1) $display("FAIL single_grant got gnt=%b sreq=%b exp 1 1", a_gnt, a_sreq); else passes++;
        step();
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) drive(0, 0, 0, 1, 32'hCAFE); else drive(0, 0, 0, 0, 0);
            checks++; if (a_out !== 3'd1) $display("FAIL single_out_c%0d got %0d exp 1", c, a_out); else passes++;
            step();
        end
        drive(0, 0, 0, 0, 0);
        checks++; if (a_out !== 3'd0 || a_unexp !== 1'b0) $display("FAIL single_done got out=%0d unexp=%b exp 0 0", a_out, a_unexp); else passes++;
        // re-check the response cycle values through a dedicated replay
        drive(1, 2, 1, 0, 0); step();
        drive(0, 0, 0, 1, 32'hCAFE);
        checks++; if (a_mv !== 4'b0100 || a_md !== 32'hCAFE) $display("FAIL single_rsp got mv=%b data=%h exp 0100 cafe", a_mv, a_md); else passes++;
        for (int k = 0; k < 2; k++) begin
            checks++; if (obs[k] !== exp_vec(k)) $display("FAIL single_vec%0d got %b exp %b", k, obs[k], exp_vec(k)); else passes++;
        end
        step();
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic test_order();
        logic [3:0] want [3] = '{4'b1000, 4'b0001, 4'b0010};
        logic [1:0] ids [3] = '{2'd3, 2'd0, 2'd1};
        for (int i = 0; i < 3; i++) begin drive(1, ids[i], 1, 0, 0); step(); end
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 1, 32'(i + 100));
            checks++; if (a_mv !== want[i] || b_mv !== want[i]) $display("FAIL order_%0d got a=%b b=%b exp %b", i, a_mv, b_mv, want[i]); else passes++;
            step();
        end
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) begin drive(1, 2'(i), 1, 0, 0); step(); end
        drive(1, 3, 1, 0, 0);
        checks++; if (a_sreq !== 1'b0 || a_gnt !== 1'b0 || a_out !== 3'd4) $display("FAIL full_block got sreq=%b gnt=%b out=%0d exp 0 0 4", a_sreq, a_gnt, a_out); else passes++;
        step();
        drive(1, 3, 1, 1, 32'h1234);
        checks++; if (a_sreq !== 1'b0 || a_gnt !== 1'b0 || a_mv !== 4'b0001) $display("FAIL full_nobypass got sreq=%b gnt=%b mv=%b exp 0 0 0001", a_sreq, a_gnt, a_mv); else passes++;
        for (int k = 0; k < 2; k++) begin
            checks++; if (obs[k] !== exp_vec(k)) $display("FAIL full_vec%0d got %b exp %b", k, obs[k], exp_vec(k)); else passes++;
        end
        step();
        drive(1, 3, 1, 0, 0);
        checks++; if (a_out !== 3'd3 || a_gnt !== 1'b1 || a_sreq !== 1'b1) $display("FAIL full_regrant got out=%0d gnt=%b sreq=%b exp 3 1 1", a_out, a_gnt, a_sreq); else passes++;
        step();
        drive(0, 0, 0, 0, 0);
        checks++; if (a_out !== 3'd4) $display("FAIL full_refill got %0d exp 4", a_out); else passes++;
        for (int i = 0; i < 4; i++) begin drive(0, 0, 0, 1, 0); step(); end
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic test_simultaneous();
        drive(1, 1, 1, 0, 0); step();
        drive(1, 2, 1, 0, 0); step();
        for (int c = 0; c < 10; c++) begin
            drive(1, 2'($urandom_range(0, 3)), 1, 1, $urandom);
            checks++; if (a_out !== 3'd2 || b_out !== 2'd2) $display("FAIL simul_c%0d got a=%0d b=%0d exp 2", c, a_out, b_out); else passes++;
            for (int k = 0; k < 2; k++) begin
                checks++; if (obs[k] !== exp_vec(k)) $display("FAIL simul_vec%0d_c%0d got %b exp %b", k, c, obs[k], exp_vec(k)); else passes++;
            end
            step();
        end
        for (int i = 0; i < 2; i++) begin drive(0, 0, 0, 1, 0); step(); end
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic test_unexpected();
        drive(0, 0, 0, 1, 32'hDEAD);
        checks++; if (a_mv !== 4'b0 || a_unexp !== 1'b0) $display("FAIL unexp_same got mv=%b unexp=%b exp 0000 0", a_mv, a_unexp); else passes++;
        step();
        drive(0, 0, 0, 0, 0);
        checks++; if (a_unexp !== 1'b1 || a_out !== 3'd0) $display("FAIL unexp_pulse got unexp=%b out=%0d exp 1 0", a_unexp, a_out); else passes++;
        step();
        checks++; if (a_unexp !== 1'b0) $display("FAIL unexp_clear got %b exp 0", a_unexp); else passes++;
        drive(1, 3, 1, 1, 32'hBEEF);
        checks++; if (a_mv !== 4'b0 || a_gnt !== 1'b1) $display("FAIL unexp_push got mv=%b gnt=%b exp 0000 1", a_mv, a_gnt); else passes++;
        step();
        drive(0, 0, 0, 1, 32'h77);
        checks++; if (a_unexp !== 1'b1 || a_out !== 3'd1 || a_mv !== 4'b1000) $display("FAIL unexp_late got unexp=%b out=%0d mv=%b exp 1 1 1000", a_unexp, a_out, a_mv); else passes++;
        step();
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin drive(1, 2'(i), 1, 0, 0); step(); end
        checks++; if (a_out !== 3'd3) $display("FAIL rstmid_pre got %0d exp 3", a_out); else passes++;
        rst = 1'b1; step(); rst = 1'b0;
        checks++; if (a_out !== 3'd0 || b_out !== 2'd0) $display("FAIL rstmid_drop got a=%0d b=%0d exp 0", a_out, b_out); else passes++;
        drive(0, 0, 0, 1, 32'h42);
        checks++; if (a_mv !== 4'b0) $display("FAIL rstmid_mv got %b exp 0000", a_mv); else passes++;
        step();
        drive(0, 0, 0, 0, 0);
        checks++; if (a_unexp !== 1'b1 || b_unexp !== 1'b1) $display("FAIL rstmid_unexp got a=%b b=%b exp 1", a_unexp, b_unexp); else passes++;
        step();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 99) < 2);
            drive(1'($urandom_range(0, 9) < 6), 2'($urandom), 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 5), $urandom);
            for (int k = 0; k < 2; k++) begin
                checks++; if (obs[k] !== exp_vec(k)) $display("FAIL rand_vec%0d_c%0d got %b exp %b", k, c, obs[k], exp_vec(k)); else passes++;
            end
            checks++; if (a_md !== rsp_d || b_md !== rsp_d) $display("FAIL rand_data_c%0d got a=%h b=%h exp %h", c, a_md, b_md, rsp_d); else passes++;
            step();
        end
        rst = 1'b0;
        drive(0, 0, 0, 0, 0);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_order();
        test_full();
        test_simultaneous();
        test_unexpected();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
